// File: rtl/rf_operand_reader.sv
`default_nettype none
// ============================================================================
// Module      : rf_operand_reader
// Description : Read-side sequencer for an 8-lane x 32-bit masked register
//               file bank with a single shared address port. Accepts one- or
//               two-source operand fetch requests, issues the reads one per
//               cycle, captures the 256-bit rows and returns them on a
//               valid/ready handshake. Writeback traffic shares the bank port
//               and always wins over reads.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               req_*                    - fetch request (valid/ready)
//               wb_*                     - writeback, always accepted
//               RF_Addr/RF_WR/RF_WR_MASK/
//               WriteData/DataOut        - bank port (1-cycle read latency)
//               op_*                     - operands out (valid/ready)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_operand_reader #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    // fetch request
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_src_a,
    input  logic [2:0]       req_src_b,
    input  logic             req_two_src,
    input  logic [TAG_W-1:0] req_tag,
    // writeback
    input  logic             wb_valid,
    input  logic [2:0]       wb_addr,
    input  logic [7:0]       wb_mask,
    input  logic [255:0]     wb_data,
    // bank port
    output logic [2:0]       RF_Addr,
    output logic             RF_WR,
    output logic [7:0]       RF_WR_MASK,
    output logic [255:0]     WriteData,
    input  logic [255:0]     DataOut,
    // operands
    output logic             op_valid,
    input  logic             op_ready,
    output logic [255:0]     op_a,
    output logic [255:0]     op_b,
    output logic [TAG_W-1:0] op_tag
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] r_src_a;
    logic [2:0] r_src_b;
    logic       r_two_src;
    logic       r_cap_a;
    logic       r_cap_b;

    // A read issues only when its state owns the bank port this cycle.
    logic w_issue_a;
    logic w_issue_b;

    assign w_issue_a = (r_state == S_RD_A) && !wb_valid;
    assign w_issue_b = (r_state == S_RD_B) && !wb_valid;

    assign req_ready = (r_state == S_IDLE);
    assign op_valid  = (r_state == S_OUT);

    // Bank port: writeback has strict priority over the pending read.
    assign RF_WR      = wb_valid;
    assign RF_WR_MASK = wb_valid ? wb_mask : 8'h00;
    assign WriteData  = wb_data;

    always_comb begin
        RF_Addr = 3'd0;
        if (wb_valid) begin
            RF_Addr = wb_addr;
        end else if (w_issue_a) begin
            RF_Addr = r_src_a;
        end else if (w_issue_b) begin
            RF_Addr = r_src_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_src_a   <= 3'd0;
            r_src_b   <= 3'd0;
            r_two_src <= 1'b0;
            r_cap_a   <= 1'b0;
            r_cap_b   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_tag    <= '0;
        end else begin
            // Capture flags mark the cycle in which the bank presents the row
            // addressed on the previous cycle; they are independent of state so
            // a writeback in the capture cycle cannot disturb the load.
            r_cap_a <= w_issue_a;
            r_cap_b <= w_issue_b;
            if (r_cap_a) begin
                op_a <= DataOut;
            end
            if (r_cap_b) begin
                op_b <= DataOut;
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_src_a   <= req_src_a;
                        r_src_b   <= req_src_b;
                        r_two_src <= req_two_src;
                        op_tag    <= req_tag;
                        // Single-source requests return a zero B operand.
                        op_b      <= '0;
                        r_state   <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    if (!wb_valid) begin
                        r_state <= r_two_src ? S_RD_B : S_WAIT;
                    end
                end
                S_RD_B: begin
                    if (!wb_valid) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (op_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_operand_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_operand_reader
// Description : Self-checking bench for rf_operand_reader with a behavioural
//               masked register-file bank and an operand scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_operand_reader;

    localparam int TAG_W = 6;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_src_a;
    logic [2:0]       req_src_b;
    logic             req_two_src;
    logic [TAG_W-1:0] req_tag;
    logic             wb_valid;
    logic [2:0]       wb_addr;
    logic [7:0]       wb_mask;
    logic [255:0]     wb_data;
    logic [2:0]       RF_Addr;
    logic             RF_WR;
    logic [7:0]       RF_WR_MASK;
    logic [255:0]     WriteData;
    logic [255:0]     DataOut;
    logic             op_valid;
    logic             op_ready;
    logic [255:0]     op_a;
    logic [255:0]     op_b;
    logic [TAG_W-1:0] op_tag;

    rf_operand_reader #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src_a  (req_src_a),
        .req_src_b  (req_src_b),
        .req_two_src(req_two_src),
        .req_tag    (req_tag),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_mask    (wb_mask),
        .wb_data    (wb_data),
        .RF_Addr    (RF_Addr),
        .RF_WR      (RF_WR),
        .RF_WR_MASK (RF_WR_MASK),
        .WriteData  (WriteData),
        .DataOut    (DataOut),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_tag     (op_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: masked write, or 1-cycle synchronous read.
    logic [255:0] bank [8];
    always_ff @(posedge clk) begin
        if (RF_WR) begin
            for (int i = 0; i < 8; i++) begin
                if (RF_WR_MASK[i]) bank[RF_Addr][i*32 +: 32] <= WriteData[i*32 +: 32];
            end
        end else begin
            DataOut <= bank[RF_Addr];
        end
    end

    // Bench-side reference contents of the register file.
    logic [255:0] exp_mem [8];

    typedef struct packed {
        logic [255:0]     a;
        logic [255:0]     b;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]       a;
        logic [2:0]       b;
        logic             two;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               wb_start;
        int               wb_len;
        logic [2:0]       wa;
        logic [7:0]       wm;
        logic [255:0]     wd;
        int               hold;
    } vec_t;
    vec_t vecs[7];

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [7:0] m,
                                           input logic [255:0] d);
        logic [255:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (m[i]) r[i*32 +: 32] = d[i*32 +: 32];
        return r;
    endfunction

    task automatic do_write(input logic [2:0] a, input logic [7:0] m, input logic [255:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_mask = m; wb_data = d;
        exp_mem[a] = merge(exp_mem[a], m, d);
        tick();
        wb_valid = 1'b0; wb_mask = 8'h00;
    endtask

    task automatic run_req(input vec_t v);
        exp_t  e;
        exp_t  got;
        int    cyc;
        bit    w;
        bit    seen;
        // A writeback in the accept cycle precedes every read issue.
        if (v.wb_len > 0 && v.wb_start == 0) exp_mem[v.wa] = merge(exp_mem[v.wa], v.wm, v.wd);
        e.a   = exp_mem[v.a];
        e.b   = v.two ? exp_mem[v.b] : 256'd0;
        e.tag = v.tag;
        sb.push_back(e);
        if (v.wb_len > 0 && v.wb_start != 0) exp_mem[v.wa] = merge(exp_mem[v.wa], v.wm, v.wd);

        req_valid = 1'b1; req_src_a = v.a; req_src_b = v.b; req_two_src = v.two; req_tag = v.tag;
        op_ready  = (v.hold == 0);
        seen = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            w = (v.wb_len > 0) && (cyc >= v.wb_start) && (cyc < v.wb_start + v.wb_len);
            wb_valid = w; wb_addr = v.wa; wb_mask = v.wm; wb_data = v.wd;
            @(negedge clk);
            if (cyc == 0) chk("req_ready_accept", {255'd0, req_ready}, 256'd1);
            if (w) begin
                chk("wb_rf_addr", {253'd0, RF_Addr}, {253'd0, v.wa});
                chk("wb_rf_mask", {248'd0, RF_WR_MASK}, {248'd0, v.wm});
            end
            if (op_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
            req_valid = 1'b0;
        end
        wb_valid = 1'b0;
        if (!seen) begin
            chk("op_valid_timeout", 256'd0, 256'd1);
            return;
        end
        chk("latency", cyc, v.lat);
        got = sb.pop_front();
        chk("op_a", op_a, got.a);
        chk("op_b", op_b, got.b);
        chk("op_tag", {250'd0, op_tag}, {250'd0, got.tag});

        if (v.hold > 0) begin
            // Backpressure: outputs must stay put and no new request may enter.
            for (int h = 1; h < v.hold; h++) begin
                tick();
                req_valid = 1'b1; req_src_a = 3'd7; req_src_b = 3'd7; req_two_src = 1'b0; req_tag = 6'h01;
                @(negedge clk);
                chk("hold_op_valid", {255'd0, op_valid}, 256'd1);
                chk("hold_req_ready", {255'd0, req_ready}, 256'd0);
                chk("hold_op_a", op_a, got.a);
                chk("hold_op_b", op_b, got.b);
                chk("hold_op_tag", {250'd0, op_tag}, {250'd0, got.tag});
            end
            req_valid = 1'b0;
            op_ready  = 1'b1;
        end
        tick();
        @(negedge clk);
        chk("post_out_idle", {255'd0, req_ready}, 256'd1);
        chk("post_out_valid", {255'd0, op_valid}, 256'd0);
        tick();
    endtask

    logic [255:0] row3, row_ff, row_new2, rowx, row4a, row4b, row1, row5, row7;

    initial begin
        n_checks = 0; n_fail = 0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 256'd0;
        rst = 1'b1; req_valid = 1'b0; req_src_a = 3'd0; req_src_b = 3'd0; req_two_src = 1'b0;
        req_tag = '0; wb_valid = 1'b0; wb_addr = 3'd0; wb_mask = 8'h00; wb_data = '0; op_ready = 1'b1;

        for (int i = 0; i < 8; i++) begin
            row3[i*32 +: 32]     = 32'h1000_0000 + i;
            row_new2[i*32 +: 32] = 32'hA000_0000 + i;
            rowx[i*32 +: 32]     = 32'hDEAD_0000 + i;
            row4a[i*32 +: 32]    = 32'h4444_0000 + i;
            row4b[i*32 +: 32]    = 32'h4B4B_0000 + i;
            row1[i*32 +: 32]     = 32'h1111_0000 + i;
            row5[i*32 +: 32]     = 32'h5555_0000 + i;
            row7[i*32 +: 32]     = 32'h7777_0000 + i;
        end
        row_ff = {256{1'b1}};

        // Reset state, and writeback pass-through while in reset.
        tick(); tick();
        @(negedge clk);
        chk("rst_req_ready", {255'd0, req_ready}, 256'd1);
        chk("rst_op_valid", {255'd0, op_valid}, 256'd0);
        chk("rst_op_a", op_a, 256'd0);
        chk("rst_op_b", op_b, 256'd0);
        chk("rst_op_tag", {250'd0, op_tag}, 256'd0);
        chk("rst_wr_mask_idle", {248'd0, RF_WR_MASK}, 256'd0);
        wb_valid = 1'b1; wb_mask = 8'h5A; wb_addr = 3'd6;
        #1;
        chk("rst_wr_mask_follow", {248'd0, RF_WR_MASK}, {248'd0, 8'h5A});
        chk("rst_wr_follow", {255'd0, RF_WR}, 256'd1);
        wb_valid = 1'b0; wb_mask = 8'h00;
        exp_mem[6] = merge(exp_mem[6], 8'h5A, wb_data);
        tick();
        rst = 1'b0;

        // Preload rows.
        do_write(3'd3, 8'hFF, row3);
        do_write(3'd2, 8'hFF, row_ff);
        do_write(3'd2, 8'h0F, row_new2);
        do_write(3'd1, 8'hFF, row1);
        do_write(3'd5, 8'hFF, row5);
        do_write(3'd7, 8'hFF, row7);

        //         a     b     two   tag    lat st len wa    wm     wd     hold
        vecs[0] = '{3'd3, 3'd3, 1'b1, 6'h05, 4, 0, 0, 3'd0, 8'h00, '0,    0};
        vecs[1] = '{3'd2, 3'd0, 1'b0, 6'h09, 3, 0, 0, 3'd0, 8'h00, '0,    0};
        vecs[2] = '{3'd3, 3'd2, 1'b1, 6'h11, 7, 1, 3, 3'd6, 8'hFF, rowx,  0};
        vecs[3] = '{3'd4, 3'd0, 1'b0, 6'h22, 3, 0, 1, 3'd4, 8'hFF, row4a, 0};
        vecs[4] = '{3'd4, 3'd0, 1'b0, 6'h23, 3, 2, 1, 3'd4, 8'hFF, row4b, 0};
        vecs[5] = '{3'd1, 3'd4, 1'b1, 6'h3F, 4, 0, 0, 3'd0, 8'h00, '0,    5};
        vecs[6] = '{3'd5, 3'd7, 1'b1, 6'h07, 4, 0, 0, 3'd0, 8'h00, '0,    0};

        for (int k = 0; k < 7; k++) run_req(vecs[k]);

        // Masked-write result checked against a hand-built row.
        chk("masked_row_model", exp_mem[2], {row_ff[255:128], row_new2[127:0]});

        // Reset while in RD_B drops the request.
        req_valid = 1'b1; req_src_a = 3'd5; req_src_b = 3'd7; req_two_src = 1'b1; req_tag = 6'h2A;
        tick();                         // c1: RD_A
        req_valid = 1'b0;
        tick();                         // c2: RD_B
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", {255'd0, req_ready}, 256'd1);
        chk("midrst_op_valid", {255'd0, op_valid}, 256'd0);
        chk("midrst_op_a", op_a, 256'd0);
        chk("midrst_op_tag", {250'd0, op_tag}, 256'd0);
        begin
            bit spurious;
            spurious = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                @(negedge clk);
                if (op_valid) spurious = 1'b1;
            end
            chk("midrst_no_output", {255'd0, spurious}, 256'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_operand_reader.md
# rf_operand_reader

Read-side controller for the 8-lane × 32-bit masked register-file bank (`BRAM_MASK`: 8 entries, 256-bit rows, per-lane write mask, 1-cycle synchronous read). It accepts operand-fetch requests for one or two source registers and sequences them onto the bank's single shared address port. It captures the 256-bit rows and presents them with a valid/ready handshake. It also owns the bank's write side: writeback traffic passes through with strict priority over reads.

## Interface
- `TAG_W`, 6: width of the request tag carried through to the operand output.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: fetch request valid.
- `req_ready` out 1: block can accept a request.
- `req_src_a` in 3: first source register address.
- `req_src_b` in 3: second source register address.
- `req_two_src` in 1: 1 = fetch A and B; 0 = fetch A only.
- `req_tag` in TAG_W: opaque tag returned with operands.
- `wb_valid` in 1: writeback valid; always accepted, no ready.
- `wb_addr` in 3: writeback register address.
- `wb_mask` in 8: per-lane write enable, bit i → lane i (bits 32i+31:32i).
- `wb_data` in 256: writeback row.
- `RF_Addr` out 3: bank address.
- `RF_WR` out 1: bank write strobe.
- `RF_WR_MASK` out 8: bank per-lane write enables.
- `WriteData` out 256: bank write data.
- `DataOut` in 256: bank read data, valid 1 cycle after address presented with no write.
- `op_valid` out 1: operands valid.
- `op_ready` in 1: consumer accepts operands.
- `op_a` out 256, `op_b` out 256, `op_tag` out TAG_W: captured operands and tag.

## Operation
- FSM states: IDLE, RD_A, RD_B, WAIT, OUT.
- IDLE: `req_ready`=1. On `req_valid`, latch src_a, src_b, two_src and tag, then go to RD_A. `req_ready`=0 in all other states.
- RD_A: if `wb_valid`, stall in RD_A. Otherwise present src_a as a read and go to RD_B if two_src, else WAIT.
- RD_B: if `wb_valid`, stall. Otherwise present src_b as a read and go to WAIT.
- WAIT: capture the last-issued read, then go to OUT. Never stalls.
- OUT: `op_valid`=1. Hold `op_a`, `op_b` and `op_tag` stable until `op_ready`, then go to IDLE.
- Capture rule: a registered flag per operand (cap_a, cap_b) is set exactly on the cycle after that operand's read issues. While the flag is high, `DataOut` loads into `op_a`/`op_b`, regardless of state or writeback activity in that cycle.
- Single-source request: `op_b` = 0.
- Bank port mux:
  - `RF_WR` = `wb_valid`.
  - `RF_WR_MASK` = `wb_valid` ? `wb_mask` : 8'h00.
  - `WriteData` = `wb_data`.
  - `RF_Addr` = `wb_valid` ? `wb_addr` : (read issuing ? src : 3'd0).
  - These outputs are combinational from inputs and state.
- Writebacks pass through in every state, including IDLE, WAIT and OUT.
- Coherence: no forwarding. The operand reflects bank contents at its read-issue edge. A write in cycle k is visible to a read issued in cycle k+1 or later. A write in the capture cycle does not corrupt the captured value.
- Upstream scoreboarding guarantees WAR/RAW ordering beyond the above.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready`=1, `op_valid`=0.
  - `op_a`, `op_b`, `op_tag` = 0; cap flags = 0.
  - `RF_WR`/`RF_WR_MASK` follow `wb_*` combinationally.
- Reset mid-operation: in-flight request dropped, no `op_valid` produced, IDLE the next cycle.
- Latency with no writebacks, accept in cycle 0:
  - Two-source: RD_A c1, RD_B c2 (captures A), WAIT c3 (captures B), `op_valid` in c4.
  - Single-source: `op_valid` in c3.
- Each `wb_valid` cycle while in RD_A/RD_B adds exactly 1 cycle of latency. Continuous writebacks starve reads indefinitely, by design.
- Throughput: one request per 5 cycles (two-source) or 4 cycles (one-source) with `op_ready` tied high. No accept while in OUT.

## Test plan
- Reset, write row 3 = lanes 0..7 = 32'h1000_0000+i (mask FF), request A=3, B=3 two_src, tag 5 → `op_valid` in c4, `op_a`=`op_b`=that row, `op_tag`=5.
- Masked write addr 2 mask 8'h0F (new lanes 0-3) over prior all-FFFF_FFFF, then request A=2 single-src → lanes 0-3 new, lanes 4-7 32'hFFFF_FFFF, `op_b`=0, `op_valid` in c3.
- Hold `wb_valid` for 3 cycles starting in c1 of a two-src request → `RF_Addr` = `wb_addr` for those cycles, `op_valid` delayed to c7, operands correct.
- Write addr 4 in cycle k, then read of addr 4 issued in k+1 → new value. Write addr 4 in the capture cycle of a read to 4 → old value captured.
- Hold `op_ready`=0 for 5 cycles in OUT, `req_valid`=1 → outputs stable, `req_ready`=0, no second accept. Release → IDLE, next request accepted.
- Assert `rst` in RD_B → next cycle IDLE, `op_valid`=0, `op_a`=0, no output for the dropped request.
